mmio_event_bank: RTL and testbench
==================================

Name: mmio_event_bank

Overview:
- Parametrised memory-mapped I/O register bank on the processor's data-memory port.
- Synchronises NUM_IN asynchronous peripheral inputs (keypad strobes, beam sensors, servo-done flags) and captures each as a level or a sticky edge event.
- Exposes a pending bitmask, a write-1-to-clear acknowledge register and an interrupt mask.
- Provides NUM_OUT 32-bit CPU-writable control registers with readback, which drive seven-segment digits, servo controls and state LEDs.

Parameters:
- NUM_IN, 16, number of input channels (1..32).
- NUM_OUT, 16, number of 32-bit output registers (1..32).
- ADDR_W, 12, data-memory word-address width.
- IN_BASE, 0, word address of input channel 0; channel i is at IN_BASE+i.
- PEND_ADDR, 32, word address of the pending bitmask.
- ACK_ADDR, 33, word address of the W1C acknowledge register.
- MASK_ADDR, 34, word address of the IRQ mask register.
- OUT_BASE, 48, word address of output register 0; register j is at OUT_BASE+j.
- EDGE_MASK, 32'hFFFF_FFFF, per-channel mode: bit=1 sticky rising-edge capture, bit=0 level pass-through.
- SYNC_STAGES, 2, synchroniser depth (>=2).

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  CPU data address.
- wdata  in  32  CPU store data.
- we  in  1  CPU store enable.
- rdata  out  32  read data for addr, valid the same cycle.
- hit  out  1  addr decodes inside this bank; the top level muxes rdata against RAM with it.
- in_sig  in  NUM_IN  raw asynchronous peripheral inputs.
- out_reg  out  NUM_OUT*32  output registers, register j at bits [32j+31:32j].
- irq  out  1  OR of (pending & mask).

Behaviour:
- Reset (reset=0, asynchronous):
  - synchroniser flops, previous-sample flops, pending, mask and all out_reg words clear to 0.
  - irq=0.
  - rdata and hit are combinational functions of addr only.
- Synchroniser: each in_sig bit passes SYNC_STAGES flops to give s[i]. A 1-cycle previous sample p[i] is kept.
- Edge channel (EDGE_MASK[i]=1):
  - rise = s[i] & ~p[i].
  - On rise, pending[i] is set on the next clock edge.
  - pending[i] holds until it is acknowledged.
- Level channel (EDGE_MASK[i]=0): pending[i] = s[i], registered. An ACK write has no effect on it.
- Latency: in_sig rising to pending visible at rdata/irq takes SYNC_STAGES+1 clock edges.
- Acknowledge: a store to ACK_ADDR clears pending[i] for every bit with wdata[i]=1. Bits with wdata[i]=0 are untouched.
- Simultaneous set and clear on the same edge for the same bit: set wins. An event arriving during its acknowledge is never lost.
- Mask: a store to MASK_ADDR loads mask[NUM_IN-1:0] from wdata. Upper wdata bits are ignored.
- irq is registered: irq <= |(pending_next & mask_next), so it updates on the same edge as pending.
- Output registers: a store to OUT_BASE+j (j<NUM_OUT) loads the full word into out_reg j on the next edge.
- Read map (zero-extended, combinational):
  - IN_BASE+i returns {31'b0, pending[i]}.
  - PEND_ADDR returns pending.
  - ACK_ADDR reads 0.
  - MASK_ADDR returns mask.
  - OUT_BASE+j returns out_reg j.
- Reads have no side effects.
- Decode:
  - hit=1 only for the NUM_IN channel addresses, PEND/ACK/MASK, and the NUM_OUT output addresses.
  - Elsewhere hit=0 and rdata=0, and stores are ignored.
  - Address compare uses the full ADDR_W bits, with no aliasing from truncated low bits.
  - Overlapping windows are a parameter error, checked by an elaboration-time assertion.
- we with an address inside an input-channel window or PEND_ADDR is ignored (read-only).
- Reset asserted mid-operation clears everything immediately; events during reset are lost by design.

Decomposition:
- Shared package mmio_pkg holds:
  - the default address constants (IN_BASE, PEND_ADDR, ACK_ADDR, MASK_ADDR, OUT_BASE);
  - the data width constant 32;
  - the output-register index constants (SEG0..SEG3, SERVO1/5/10/25, LED state words).
- One sub-module, mmio_sync_edge: per-channel synchroniser, previous sample and rise detect, parametrised by SYNC_STAGES. It is instantiated NUM_IN times via generate.

Test Plan:
- Reset: with reset=0, drive in_sig=16'hFFFF and stores to all addresses -> out_reg all 0, pending=0, irq=0. Release reset and read PEND_ADDR -> 0 until the sync latency elapses.
- Edge capture and W1C, channel 3:
  - Pulse in_sig[3] high for 1 cycle -> rdata at IN_BASE+3 = 1 exactly 3 edges later, PEND_ADDR = 32'h0000_0008.
  - Store 32'h8 to ACK_ADDR -> PEND = 0.
  - Store 32'h4 to ACK_ADDR instead -> bit 3 is retained.
- Set/clear collision: time a rise on channel 5 to land on the same edge as an ACK write of 32'h20 -> pending[5] stays 1.
- Level mode (EDGE_MASK bit 2=0): hold in_sig[2] high -> pending[2]=1. Write ACK 32'h4 -> still 1. Drop in_sig[2] -> 0 after 3 edges.
- IRQ: write MASK=32'h2, then raise in_sig[1] -> irq=1 on the same edge pending[1] sets. Write MASK=0 -> irq=0 on the next edge.
- Outputs and decode:
  - Store 32'hDEAD_BEEF to OUT_BASE+4 -> out_reg 4 = 32'hDEAD_BEEF and readback matches.
  - Store to address 12'h100 -> hit=0, rdata=0, no register changes.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO event bank.
//   - Default word addresses of the input, pending, acknowledge, mask and
//     output-register windows.
//   - Bus data width.
//   - Output-register index assignments used by the board top level.
//   - Register-select enum and a window-overlap helper for the decoder.
package mmio_pkg;

    localparam int unsigned DATA_W        = 32;

    localparam int unsigned DEF_IN_BASE   = 0;
    localparam int unsigned DEF_PEND_ADDR = 32;
    localparam int unsigned DEF_ACK_ADDR  = 33;
    localparam int unsigned DEF_MASK_ADDR = 34;
    localparam int unsigned DEF_OUT_BASE  = 48;

    // Output register indices (offset from OUT_BASE)
    localparam int unsigned SEG0       = 0;
    localparam int unsigned SEG1       = 1;
    localparam int unsigned SEG2       = 2;
    localparam int unsigned SEG3       = 3;
    localparam int unsigned SERVO1     = 4;
    localparam int unsigned SERVO5     = 5;
    localparam int unsigned SERVO10    = 6;
    localparam int unsigned SERVO25    = 7;
    localparam int unsigned LED_STATE0 = 8;
    localparam int unsigned LED_STATE1 = 9;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_IN,
        SEL_PEND,
        SEL_ACK,
        SEL_MASK,
        SEL_OUT
    } reg_sel_e;

    // True when [a_lo, a_lo+a_n) and [b_lo, b_lo+b_n) share any address.
    function automatic logic win_overlap(input longint a_lo, input longint a_n,
                                         input longint b_lo, input longint b_n);
        return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
    endfunction

endpackage

// File: rtl/mmio_sync_edge.sv
// One input channel: multi-flop synchroniser, one-cycle previous sample and
// rising-edge detect.
//   i_clock    system clock
//   i_reset_n  asynchronous active-low reset
//   i_async    raw asynchronous input
//   o_sync     synchronised level
//   o_rise     synchronised level is 1 and previous sample was 0
module mmio_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/mmio_event_bank.sv
// Memory-mapped peripheral register bank on the CPU data-memory port.
// Synchronises NUM_IN asynchronous inputs into a pending bitmask (sticky
// rising-edge or level per channel), with a write-1-to-clear acknowledge,
// an interrupt mask and NUM_OUT CPU-writable 32-bit control registers.
//   i_clock    system clock
//   i_reset_n  asynchronous active-low reset
//   i_addr     CPU word address
//   i_wdata    CPU store data
//   i_we       CPU store enable
//   o_rdata    combinational read data for i_addr
//   o_hit      i_addr decodes inside this bank
//   i_in_sig   raw asynchronous peripheral inputs
//   o_out_reg  output registers, register j at [32j+31:32j]
//   o_irq      registered OR of pending & mask
module mmio_event_bank
    import mmio_pkg::*;
#(
    parameter int unsigned NUM_IN      = 16,
    parameter int unsigned NUM_OUT     = 16,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned IN_BASE     = DEF_IN_BASE,
    parameter int unsigned PEND_ADDR   = DEF_PEND_ADDR,
    parameter int unsigned ACK_ADDR    = DEF_ACK_ADDR,
    parameter int unsigned MASK_ADDR   = DEF_MASK_ADDR,
    parameter int unsigned OUT_BASE    = DEF_OUT_BASE,
    parameter logic [31:0] EDGE_MASK   = 32'hFFFF_FFFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic                      i_we,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_hit,
    input  logic [NUM_IN-1:0]         i_in_sig,
    output logic [NUM_OUT*DATA_W-1:0] o_out_reg,
    output logic                      o_irq
);

    // Parameter sanity: window overlaps, range limits, address fit.
    localparam logic MAP_BAD =
        win_overlap(IN_BASE,   NUM_IN, PEND_ADDR, 1)       ||
        win_overlap(IN_BASE,   NUM_IN, ACK_ADDR,  1)       ||
        win_overlap(IN_BASE,   NUM_IN, MASK_ADDR, 1)       ||
        win_overlap(IN_BASE,   NUM_IN, OUT_BASE,  NUM_OUT) ||
        win_overlap(OUT_BASE,  NUM_OUT, PEND_ADDR, 1)      ||
        win_overlap(OUT_BASE,  NUM_OUT, ACK_ADDR,  1)      ||
        win_overlap(OUT_BASE,  NUM_OUT, MASK_ADDR, 1)      ||
        (PEND_ADDR == ACK_ADDR) || (PEND_ADDR == MASK_ADDR) ||
        (ACK_ADDR  == MASK_ADDR);

    localparam logic RANGE_BAD =
        (NUM_IN < 1) || (NUM_IN > 32) || (NUM_OUT < 1) || (NUM_OUT > 32) ||
        (SYNC_STAGES < 2) || (ADDR_W < 1) || (ADDR_W > 32) ||
        (longint'(IN_BASE)  + NUM_IN  > (longint'(1) << ADDR_W)) ||
        (longint'(OUT_BASE) + NUM_OUT > (longint'(1) << ADDR_W)) ||
        (longint'(PEND_ADDR) >= (longint'(1) << ADDR_W)) ||
        (longint'(ACK_ADDR)  >= (longint'(1) << ADDR_W)) ||
        (longint'(MASK_ADDR) >= (longint'(1) << ADDR_W));

    generate
        if (MAP_BAD) begin : g_map_bad
            $error("mmio_event_bank: address windows overlap");
        end
        if (RANGE_BAD) begin : g_range_bad
            $error("mmio_event_bank: parameter out of range");
        end
    endgenerate

    logic [NUM_IN-1:0]  w_sync;
    logic [NUM_IN-1:0]  w_rise;
    logic [NUM_IN-1:0]  r_pend;
    logic [NUM_IN-1:0]  r_mask;
    logic               r_irq;
    logic [DATA_W-1:0]  r_out [NUM_OUT];

    logic [31:0]        w_addr_ext;
    reg_sel_e           w_sel;
    logic [NUM_IN-1:0]  w_in_onehot;
    logic [NUM_OUT-1:0] w_out_onehot;
    logic [NUM_IN-1:0]  w_ack_clr;
    logic [NUM_IN-1:0]  w_pend_next;
    logic [NUM_IN-1:0]  w_mask_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
            mmio_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .i_clock   (i_clock),
                .i_reset_n (i_reset_n),
                .i_async   (i_in_sig[gi]),
                .o_sync    (w_sync[gi]),
                .o_rise    (w_rise[gi])
            );
        end
    endgenerate

    // Full-width compare: zero-extend so no low-bit aliasing can occur.
    assign w_addr_ext = 32'(i_addr);

    always_comb begin
        w_in_onehot  = '0;
        w_out_onehot = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_in_onehot[i] = (w_addr_ext == IN_BASE + i);
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            w_out_onehot[j] = (w_addr_ext == OUT_BASE + j);
        end
    end

    always_comb begin
        w_sel = SEL_NONE;
        if (|w_in_onehot)                  w_sel = SEL_IN;
        else if (w_addr_ext == PEND_ADDR)  w_sel = SEL_PEND;
        else if (w_addr_ext == ACK_ADDR)   w_sel = SEL_ACK;
        else if (w_addr_ext == MASK_ADDR)  w_sel = SEL_MASK;
        else if (|w_out_onehot)            w_sel = SEL_OUT;
    end

    assign o_hit = (w_sel != SEL_NONE);

    always_comb begin
        o_rdata = '0;
        case (w_sel)
            SEL_IN: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (w_in_onehot[i]) o_rdata[0] = r_pend[i];
                end
            end
            SEL_PEND: o_rdata[NUM_IN-1:0] = r_pend;
            SEL_MASK: o_rdata[NUM_IN-1:0] = r_mask;
            SEL_OUT: begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    if (w_out_onehot[j]) o_rdata = r_out[j];
                end
            end
            default: o_rdata = '0;
        endcase
    end

    // Next-state for pending and mask. Edge channels: a rise on the same
    // edge as an acknowledge wins, so no event is dropped. Level channels
    // simply follow the synchronised input and ignore acknowledges.
    always_comb begin
        w_ack_clr   = '0;
        w_mask_next = r_mask;
        if (i_we && (w_sel == SEL_ACK))  w_ack_clr   = i_wdata[NUM_IN-1:0];
        if (i_we && (w_sel == SEL_MASK)) w_mask_next = i_wdata[NUM_IN-1:0];
        for (int i = 0; i < NUM_IN; i++) begin
            w_pend_next[i] = EDGE_MASK[i] ? ((r_pend[i] & ~w_ack_clr[i]) | w_rise[i])
                                          : w_sync[i];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend <= '0;
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_mask <= w_mask_next;
            r_irq  <= |(w_pend_next & w_mask_next);
        end
    end

    assign o_irq = r_irq;

    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_out[gi] <= '0;
                end else if (i_we && w_out_onehot[gi]) begin
                    r_out[gi] <= i_wdata;
                end
            end
            assign o_out_reg[DATA_W*gi +: DATA_W] = r_out[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mmio_event_bank.sv
module tb_mmio_event_bank;

    localparam int NUM_IN  = 16;
    localparam int NUM_OUT = 16;
    localparam int ADDR_W  = 12;
    localparam logic [11:0] A_PEND = 12'd32;
    localparam logic [11:0] A_ACK  = 12'd33;
    localparam logic [11:0] A_MASK = 12'd34;
    localparam logic [11:0] A_OUT  = 12'd48;

    logic                    clk;
    logic                    rst_n;
    logic [ADDR_W-1:0]       addr;
    logic [31:0]             wdata;
    logic                    we;
    logic [31:0]             rdata;
    logic                    hit;
    logic [NUM_IN-1:0]       in_sig;
    logic [NUM_OUT*32-1:0]   out_reg;
    logic                    irq;

    int checks = 0;
    int errors = 0;
    logic [NUM_OUT*32-1:0]   exp_out;

    mmio_event_bank #(
        .NUM_IN    (NUM_IN),
        .NUM_OUT   (NUM_OUT),
        .ADDR_W    (ADDR_W),
        .EDGE_MASK (32'hFFFF_FFFB)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .i_we      (we),
        .o_rdata   (rdata),
        .o_hit     (hit),
        .i_in_sig  (in_sig),
        .o_out_reg (out_reg),
        .o_irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [ADDR_W-1:0] a,
                          input logic [31:0] exp);
        addr = a;
        #1;
        checks++;
        if (rdata !== exp) begin
            errors++;
            $display("FAIL %s: rdata@%h got %h expected %h", name, a, rdata, exp);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        in_sig = 16'hFFFF;
        for (int a = 0; a < 64; a++) wr(12'(a), 32'hFFFF_FFFF);
        checks++;
        if (out_reg !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0", out_reg);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        chk_rd("reset_pend", A_PEND, 32'h0);
        chk_rd("reset_mask", A_MASK, 32'h0);
        rst_n = 1'b1;
        addr  = A_PEND;
        tick();
        chk_rd("rel_pend_e1", A_PEND, 32'h0);
        tick();
        chk_rd("rel_pend_e2", A_PEND, 32'h0);
        tick();
        chk_rd("rel_pend_e3", A_PEND, 32'h0000_FFFF);
        // drain: drop inputs, let level channel fall, clear edge events
        in_sig = '0;
        repeat (3) tick();
        wr(A_ACK, 32'hFFFF_FFFF);
        chk_rd("rel_cleared", A_PEND, 32'h0);
    endtask

    task automatic test_edge_w1c();
        in_sig[3] = 1'b1;
        tick();
        in_sig[3] = 1'b0;
        chk_rd("edge3_e1", 12'd3, 32'h0);
        tick();
        chk_rd("edge3_e2", 12'd3, 32'h0);
        tick();
        chk_rd("edge3_e3", 12'd3, 32'h1);
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL edge3_hit: got %b expected 1", hit);
        end
        chk_rd("edge3_pend", A_PEND, 32'h0000_0008);
        repeat (4) tick();
        chk_rd("edge3_sticky", A_PEND, 32'h0000_0008);
        wr(A_ACK, 32'h4);
        chk_rd("ack_other_bit", A_PEND, 32'h0000_0008);
        wr(A_ACK, 32'h8);
        chk_rd("ack_bit3", A_PEND, 32'h0);
        chk_rd("ack_reads0", A_ACK, 32'h0);
    endtask

    task automatic test_collision();
        in_sig[5] = 1'b1;
        repeat (3) tick();
        chk_rd("col_first", A_PEND, 32'h20);
        in_sig[5] = 1'b0;
        repeat (3) tick();
        in_sig[5] = 1'b1;
        repeat (2) tick();
        wr(A_ACK, 32'h20);   // lands on the same edge as the new rise
        chk_rd("col_set_wins", A_PEND, 32'h20);
        wr(A_ACK, 32'h20);
        chk_rd("col_then_clear", A_PEND, 32'h0);
        in_sig[5] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_level();
        in_sig[2] = 1'b1;
        repeat (2) tick();
        chk_rd("lvl_e2", 12'd2, 32'h0);
        tick();
        chk_rd("lvl_e3", 12'd2, 32'h1);
        wr(A_ACK, 32'h4);
        chk_rd("lvl_ack_noeff", 12'd2, 32'h1);
        in_sig[2] = 1'b0;
        repeat (2) tick();
        chk_rd("lvl_fall_e2", 12'd2, 32'h1);
        tick();
        chk_rd("lvl_fall_e3", 12'd2, 32'h0);
    endtask

    task automatic test_irq();
        wr(A_MASK, 32'hFFFF_0002);
        chk_rd("mask_upper_ignored", A_MASK, 32'h2);
        in_sig[1] = 1'b1;
        repeat (2) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b expected 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b expected 1", irq);
        end
        chk_rd("irq_pend", A_PEND, 32'h2);
        in_sig[1] = 1'b0;
        wr(A_MASK, 32'h0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked: got %b expected 0", irq);
        end
        chk_rd("irq_pend_kept", A_PEND, 32'h2);
        wr(A_ACK, 32'h2);
        chk_rd("irq_pend_ack", A_PEND, 32'h0);
    endtask

    task automatic test_outputs_decode();
        exp_out = '0;
        wr(A_OUT + 12'd4, 32'hDEAD_BEEF);
        exp_out[4*32 +: 32] = 32'hDEAD_BEEF;
        checks++;
        if (out_reg !== exp_out) begin
            errors++;
            $display("FAIL out4: got %h expected %h", out_reg[4*32 +: 32], 32'hDEAD_BEEF);
        end
        chk_rd("out4_rb", A_OUT + 12'd4, 32'hDEAD_BEEF);
        // back-to-back stores to first and last register
        wr(A_OUT, 32'h1111_0000);
        wr(A_OUT + 12'd15, 32'hCAFE_F00D);
        exp_out[0 +: 32]     = 32'h1111_0000;
        exp_out[15*32 +: 32] = 32'hCAFE_F00D;
        checks++;
        if (out_reg !== exp_out) begin
            errors++;
            $display("FAIL out_b2b: got %h expected %h", out_reg, exp_out);
        end
        chk_rd("out15_rb", A_OUT + 12'd15, 32'hCAFE_F00D);
        // unmapped and aliasing-candidate addresses
        addr = 12'h100; wdata = 32'h1234_5678; we = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_100: hit %b rdata %h expected 0 0", hit, rdata);
        end
        tick();
        we = 1'b0;
        foreach (exp_out[k]) ;  // no-op keeps exp_out unchanged
        wr(12'h830, 32'h5555_5555);  // 48 + 0x800: must not alias OUT_BASE
        wr(12'd64, 32'h6666_6666);   // one past the last output register
        wr(A_PEND, 32'hFFFF_FFFF);   // read-only
        wr(12'd7, 32'hFFFF_FFFF);    // read-only input channel
        checks++;
        if (out_reg !== exp_out) begin
            errors++;
            $display("FAIL decode_nochange: got %h expected %h", out_reg, exp_out);
        end
        chk_rd("pend_ro", A_PEND, 32'h0);
        chk_rd("mask_unchanged", A_MASK, 32'h0);
        addr = 12'h830;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL decode_alias_hit: got %b expected 0", hit);
        end
        addr = 12'd16;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL decode_in_end_hit: got %b expected 0", hit);
        end
        addr = 12'd35;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL decode_35_hit: got %b expected 0", hit);
        end
    endtask

    task automatic test_midop_reset();
        in_sig[0] = 1'b1;
        repeat (3) tick();
        wr(A_MASK, 32'h1);
        chk_rd("midop_pre", A_PEND, 32'h1);
        rst_n = 1'b0;   // mid-cycle, away from any edge
        #1;
        checks++;
        if (out_reg !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: out %h irq %b expected 0 0", out_reg, irq);
        end
        chk_rd("midop_pend", A_PEND, 32'h0);
        chk_rd("midop_mask", A_MASK, 32'h0);
        tick();
        rst_n = 1'b1;
        in_sig = '0;
    endtask

    initial begin
        rst_n  = 1'b0;
        addr   = '0;
        wdata  = '0;
        we     = 1'b0;
        in_sig = '0;
        test_reset();
        test_edge_w1c();
        test_collision();
        test_level();
        test_irq();
        test_outputs_decode();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
